// File: rtl/decoder_n2m_seq_pkg.sv
// decoder_pkg: shared FSM state type, one-hot decode and counter width helpers for decoder_n2m_seq.
package decoder_pkg;
    typedef enum logic [1:0] {IDLE, DIRECT, SWEEP} dec_state_t;
    localparam int MAX_SEL_W = 6;
    localparam int MAX_OUT_W = 1 << MAX_SEL_W;
    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
        return MAX_OUT_W'(1) << sel;
    endfunction
    function automatic int cnt_w(input int dwell);
        return dwell > 1 ? $clog2(dwell) : 1;
    endfunction
endpackage

// File: rtl/decoder_n2m_seq_dwell_counter.sv
// dwell_counter: counts cycles spent at one sweep position; tick marks the last one.
module dwell_counter
    import decoder_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic tick
);
    localparam int CW = cnt_w(DWELL);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);
    logic [CW-1:0] cnt;
    assign tick = run && cnt == LAST;
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (run) cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/decoder_n2m_seq.sv
// decoder_n2m_seq: registered N-to-2^N one-hot decoder with handshake and sweep mode.
// Define DECODER_N2M_ACTIVE_LOW_EN for one-cold (inverted) y.
module decoder_n2m_seq
    import decoder_pkg::*;
#(
    parameter int SEL_W = 2,
    parameter int DWELL = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    mode,
    input  logic                    sel_valid,
    input  logic [SEL_W-1:0]        sel,
    output logic                    sel_ready,
    output logic [(1<<SEL_W)-1:0]   y,
    output logic                    y_valid,
    output logic                    sweep_done
);
    localparam int OUT_W = 1 << SEL_W;
    if (SEL_W < 1 || SEL_W > MAX_SEL_W || DWELL < 1) begin : g_bad_param
        $error("decoder_n2m_seq: SEL_W must be 1..6 and DWELL >= 1");
    end
    dec_state_t state;
    logic [SEL_W-1:0] idx, pos, nxt;
    logic [OUT_W-1:0] y_h;
    logic accept, tick;
    assign sel_ready = !rst && en && state != SWEEP;
    assign accept = sel_valid && sel_ready;
    assign nxt = idx + 1'b1;
    dwell_counter #(.DWELL(DWELL)) u_dwell (
        .clk(clk),
        .rst(rst),
        .clr(accept),
        .run(state == SWEEP),
        .tick(tick)
    );
    // pos counts completed positions; all-ones means the last position just finished
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            pos        <= '0;
            y_h        <= '0;
            y_valid    <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            if (!en) begin
                state   <= IDLE;
                y_h     <= '0;
                y_valid <= 1'b0;
            end else if (accept) begin
                state   <= mode ? SWEEP : DIRECT;
                idx     <= sel;
                pos     <= '0;
                y_h     <= OUT_W'(onehot(MAX_SEL_W'(sel)));
                y_valid <= 1'b1;
            end else if (state == SWEEP && tick) begin
                if (&pos) begin
                    state      <= IDLE;
                    y_h        <= '0;
                    y_valid    <= 1'b0;
                    sweep_done <= 1'b1;
                end else begin
                    idx <= nxt;
                    pos <= pos + 1'b1;
                    y_h <= OUT_W'(onehot(MAX_SEL_W'(nxt)));
                end
            end
        end
    end
`ifdef DECODER_N2M_ACTIVE_LOW_EN
    assign y = ~y_h;
    a_onehot: assert property (@(posedge clk) $onehot0(~y));
`else
    assign y = y_h;
    a_onehot: assert property (@(posedge clk) $onehot0(y));
`endif
endmodule

// File: tb/tb_decoder_n2m_seq.sv
// tb_decoder_n2m_seq: scoreboard bench for two decoder_n2m_seq configurations.
module tb_decoder_n2m_seq;
`ifdef DECODER_N2M_ACTIVE_LOW_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int total = 0, bad = 0;

    logic a_rst, a_en, a_mode, a_valid, a_ready, a_yv, a_done;
    logic [1:0] a_sel;
    logic [3:0] a_y, a_yh;
    logic b_rst, b_en, b_mode, b_valid, b_ready, b_yv, b_done;
    logic [2:0] b_sel;
    logic [7:0] b_y, b_yh;

    decoder_n2m_seq #(.SEL_W(2), .DWELL(3)) dut_a (
        .clk(clk), .rst(a_rst), .en(a_en), .mode(a_mode), .sel_valid(a_valid), .sel(a_sel),
        .sel_ready(a_ready), .y(a_y), .y_valid(a_yv), .sweep_done(a_done));
    decoder_n2m_seq #(.SEL_W(3), .DWELL(1)) dut_b (
        .clk(clk), .rst(b_rst), .en(b_en), .mode(b_mode), .sel_valid(b_valid), .sel(b_sel),
        .sel_ready(b_ready), .y(b_y), .y_valid(b_yv), .sweep_done(b_done));

    assign a_yh = INV ? ~a_y : a_y;
    assign b_yh = INV ? ~b_y : b_y;

    logic [4:0] qa[$];
    logic [8:0] qb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (!$onehot0(a_yh)) chk("a_onehot", 64'(a_yh), 64'(0));
        if (!$onehot0(b_yh)) chk("b_onehot", 64'(b_yh), 64'(0));
        if (a_yv || a_done) begin
            if (qa.size() == 0) chk("a_unexpected", 64'({a_done, a_yh}), 64'(0));
            else chk("a_out", 64'({a_done, a_yv, a_yh}), 64'({qa[0][4], ~qa[0][4], qa[0][3:0]}));
            if (qa.size() != 0) void'(qa.pop_front());
        end
        if (b_yv || b_done) begin
            if (qb.size() == 0) chk("b_unexpected", 64'({b_done, b_yh}), 64'(0));
            else chk("b_out", 64'({b_done, b_yv, b_yh}), 64'({qb[0][8], ~qb[0][8], qb[0][7:0]}));
            if (qb.size() != 0) void'(qb.pop_front());
        end
    end

    logic [3:0] sweep_a[12] = '{4'b1000, 4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0001,
                                4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0100};
    logic [7:0] sweep_b[8] = '{8'b01000000, 8'b10000000, 8'b00000001, 8'b00000010,
                               8'b00000100, 8'b00001000, 8'b00010000, 8'b00100000};

    initial begin
        a_rst = 1; a_en = 1; a_mode = 0; a_valid = 0; a_sel = 0;
        b_rst = 1; b_en = 1; b_mode = 0; b_valid = 0; b_sel = 0;
        step(2);
        chk("rst_ready", 64'(a_ready), 64'(0));
        chk("rst_y", 64'(a_y), INV ? 64'hF : 64'h0);
        chk("rst_yv", 64'(a_yv), 64'(0));
        chk("rst_done", 64'(a_done), 64'(0));
        a_rst = 0; b_rst = 0;
        #1 chk("rel_ready", 64'(a_ready), 64'(1));
        step();
        chk("idle_y", 64'(a_y), INV ? 64'hF : 64'h0);
        // direct back-to-back
        a_valid = 1; a_mode = 0; a_sel = 2; qa.push_back(5'b0_0100);
        step();
        a_sel = 3; qa.push_back(5'b0_1000);
        step();
        chk("direct_y", 64'(a_yh), 64'b1000);
        a_valid = 0; a_en = 0;
        step();
        chk("en_off_yv", 64'(a_yv), 64'(0));
        chk("en_off_y", 64'(a_yh), 64'(0));
        // en low together with sel_valid: no accept
        a_valid = 1;
        #1 chk("en_off_ready", 64'(a_ready), 64'(0));
        step(2);
        a_valid = 0; a_en = 1;
        step();
        // full sweep from 3, DWELL=3
        a_valid = 1; a_mode = 1; a_sel = 3;
        foreach (sweep_a[i]) qa.push_back({1'b0, sweep_a[i]});
        qa.push_back(5'b1_0000);
        step();
        a_valid = 0;
        for (int i = 0; i < 12; i++) begin
            chk("sweep_ready", 64'(a_ready), 64'(0));
            step();
        end
        chk("done_ready", 64'(a_ready), 64'(1));
        chk("done_pulse", 64'(a_done), 64'(1));
        step();
        chk("done_once", 64'(a_done), 64'(0));
        // abort on cycle 5 of a sweep from 0
        a_valid = 1; a_mode = 1; a_sel = 0;
        qa.push_back(5'b0_0001); qa.push_back(5'b0_0001); qa.push_back(5'b0_0001);
        qa.push_back(5'b0_0010); qa.push_back(5'b0_0010);
        step();
        a_valid = 0;
        step(4);
        a_en = 0;
        step();
        chk("abort_yv", 64'(a_yv), 64'(0));
        chk("abort_y", 64'(a_yh), 64'(0));
        chk("abort_done", 64'(a_done), 64'(0));
        chk("abort_en_off_y", 64'(a_y), INV ? 64'hF : 64'h0);
        step(14);
        a_en = 1; a_valid = 1; a_mode = 0; a_sel = 1; qa.push_back(5'b0_0010);
        step();
        a_valid = 0;
        chk("after_abort_y", 64'(a_yh), 64'b0010);
        a_en = 0;
        step();
        // DUT b: reset mid-sweep, DWELL=1
        b_valid = 1; b_mode = 1; b_sel = 2;
        qb.push_back(9'b0_00000100); qb.push_back(9'b0_00001000);
        qb.push_back(9'b0_00010000); qb.push_back(9'b0_00100000);
        step();
        b_valid = 0;
        step(3);
        b_rst = 1;
        step();
        chk("b_rst_y", 64'(b_yh), 64'(0));
        chk("b_rst_yv", 64'(b_yv), 64'(0));
        chk("b_rst_done", 64'(b_done), 64'(0));
        b_rst = 0;
        step(10);
        b_valid = 1; b_mode = 1; b_sel = 6;
        foreach (sweep_b[i]) qb.push_back({1'b0, sweep_b[i]});
        qb.push_back(9'b1_00000000);
        step();
        b_valid = 0;
        step(8);
        chk("b_done", 64'(b_done), 64'(1));
        step(3);
        chk("qa_drained", 64'(qa.size()), 64'(0));
        chk("qb_drained", 64'(qb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
